// File: rtl/cpu_decode_buf.sv
// mox125 decode stage: decodes fetched instructions, flags illegal opcodes and
// hazards, and queues the results in a DEPTH-entry valid/ready buffer.
module cpu_decode_buf #(
  parameter int PCB_W      = 6,
  parameter int DEPTH      = 2,
  parameter int FWD_STAGES = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    flush_i,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  input  logic [15:0]             opcode_i,
  input  logic [31:0]             operand_i,
  input  logic [31:0]             PC_i,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic [PCB_W-1:0]        pcb_o,
  output logic [15:0]             opcode_o,
  output logic [3:0]              riA_o,
  output logic [3:0]              riB_o,
  output logic [31:0]             operand_o,
  output logic [31:0]             pcrel_target_o,
  output logic [31:0]             PC_o,
  output logic                    bad_o,
  output logic [2*FWD_STAGES-1:0] fwd_a_o,
  output logic [2*FWD_STAGES-1:0] fwd_b_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  // Pipeline control bit positions: register A write, register B write, ALU, load, store.
  localparam int PCB_WA  = 5;
  localparam int PCB_WB  = 4;
  localparam int PCB_ALU = 3;
  localparam int PCB_LD  = 2;
  localparam int PCB_ST  = 1;

  typedef struct packed {
    logic [PCB_W-1:0]        pcb;
    logic [15:0]             opcode;
    logic [3:0]              ria;
    logic [3:0]              rib;
    logic [31:0]             operand;
    logic [31:0]             target;
    logic [31:0]             pc;
    logic                    bad;
    logic [2*FWD_STAGES-1:0] fwd_a;
    logic [2*FWD_STAGES-1:0] fwd_b;
  } entry_t;

  typedef struct packed {
    logic       valid;
    logic       wa;
    logic       wb;
    logic [3:0] ria;
    logic [3:0] rib;
  } hist_t;

  entry_t          slots [DEPTH];
  hist_t           hist  [FWD_STAGES];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count, count_next;
  logic            rdy_q;
  logic            accept, consume;
  entry_t          dec;
  entry_t          head;

  function automatic logic [PCB_W-1:0] microcode(input logic [7:0] op);
    logic [PCB_W-1:0] p;
    p = '0;
    case (op) inside
      8'h01, 8'h02:                           p[PCB_WA] = 1'b1;
      8'h05, 8'h0E, [8'h26:8'h2F], [8'h31:8'h36]: begin
        p[PCB_WA]  = 1'b1;
        p[PCB_ALU] = 1'b1;
      end
      8'h0A, 8'h0C: begin
        p[PCB_WA] = 1'b1;
        p[PCB_LD] = 1'b1;
      end
      8'h0B, 8'h0D:                           p[PCB_ST] = 1'b1;
      8'h06: begin
        p[PCB_WA] = 1'b1;
        p[PCB_ST] = 1'b1;
      end
      8'h07: begin
        p[PCB_WA] = 1'b1;
        p[PCB_WB] = 1'b1;
        p[PCB_LD] = 1'b1;
      end
      default:                                p = '0;
    endcase
    return p;
  endfunction

  assign in_ready_o  = rdy_q;
  assign out_valid_o = (count != '0);
  assign accept      = in_valid_i & rdy_q;
  assign consume     = out_valid_o & out_ready_i;

  always_comb begin
    // NOTE: every field gets a default first so no path through this block infers a latch.
    dec        = '0;
    dec.opcode = opcode_i;
    dec.pc     = PC_i;
    dec.bad    = (opcode_i[15:8] == 8'h00) ||
                 (opcode_i[15:8] inside {[8'h14:8'h18], [8'h3A:8'h3F]}) ||
                 (opcode_i[15:12] == 4'hE && opcode_i[11]) ||
                 (opcode_i[15:12] == 4'hF);
    if (!opcode_i[15]) begin
      dec.ria     = opcode_i[7:4];
      dec.rib     = opcode_i[3:0];
      dec.pcb     = microcode(opcode_i[15:8]);
      dec.operand = operand_i;
    end else if (!opcode_i[14]) begin
      dec.ria     = opcode_i[11:8];
      dec.rib     = opcode_i[3:0];
      dec.operand = {24'h0, opcode_i[7:0]};
      if (!opcode_i[13]) begin
        dec.pcb[PCB_WA]  = 1'b1;
        dec.pcb[PCB_ALU] = 1'b1;
      end
    end else begin
      dec.ria = opcode_i[11:8];
      dec.rib = opcode_i[3:0];
      // Every legal form-3 opcode is a conditional branch.
      if (!dec.bad)
        dec.target = PC_i + 32'd2 + {{21{opcode_i[9]}}, opcode_i[9:0], 1'b0};
    end
    if (dec.bad)
      dec.pcb = '0;
    for (int k = 0; k < FWD_STAGES; k++) begin
      dec.fwd_a[2*k]   = hist[k].valid & hist[k].wa & (hist[k].ria == dec.ria);
      dec.fwd_a[2*k+1] = hist[k].valid & hist[k].wb & (hist[k].rib == dec.ria);
      dec.fwd_b[2*k]   = hist[k].valid & hist[k].wa & (hist[k].ria == dec.rib);
      dec.fwd_b[2*k+1] = hist[k].valid & hist[k].wb & (hist[k].rib == dec.rib);
    end
  end

  always_comb begin
    count_next = count;
    if (accept && !consume)
      count_next = count + CW'(1);
    else if (!accept && consume)
      count_next = count - CW'(1);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      rdy_q  <= 1'b0;
      for (int k = 0; k < FWD_STAGES; k++)
        hist[k] <= '0;
      // NOTE: the queue slots are reset too, because the head fields are visible while empty.
      for (int i = 0; i < DEPTH; i++)
        slots[i] <= '0;
    end else if (flush_i) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      rdy_q  <= 1'b1;
      for (int k = 0; k < FWD_STAGES; k++)
        hist[k] <= '0;
    end else begin
      if (accept) begin
        slots[wr_ptr] <= dec;
        wr_ptr        <= wr_ptr + AW'(1);
        for (int k = FWD_STAGES - 1; k > 0; k--)
          hist[k] <= hist[k-1];
        hist[0] <= '{valid: 1'b1, wa: dec.pcb[PCB_WA], wb: dec.pcb[PCB_WB],
                     ria: dec.ria, rib: dec.rib};
      end
      if (consume)
        rd_ptr <= rd_ptr + AW'(1);
      count <= count_next;
      rdy_q <= (count_next != CW'(DEPTH));
    end
  end

  assign head           = slots[rd_ptr];
  assign pcb_o          = head.pcb;
  assign opcode_o       = head.opcode;
  assign riA_o          = head.ria;
  assign riB_o          = head.rib;
  assign operand_o      = head.operand;
  assign pcrel_target_o = head.target;
  assign PC_o           = head.pc;
  assign bad_o          = head.bad;
  assign fwd_a_o        = head.fwd_a;
  assign fwd_b_o        = head.fwd_b;

endmodule

// File: tb/tb_cpu_decode_buf.sv
// Directed bench for cpu_decode_buf: a decode vector table followed by
// backpressure, flush and reset sequences.
module tb_cpu_decode_buf;

  logic        clk = 1'b0;
  logic        rst_i, flush_i, in_valid_i, in_ready_o, out_valid_o, out_ready_i;
  logic [15:0] opcode_i, opcode_o;
  logic [31:0] operand_i, PC_i, operand_o, pcrel_target_o, PC_o;
  logic [5:0]  pcb_o;
  logic [3:0]  riA_o, riB_o, fwd_a_o, fwd_b_o;
  logic        bad_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  cpu_decode_buf #(.PCB_W(6), .DEPTH(2), .FWD_STAGES(2)) dut (
    .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .opcode_i(opcode_i), .operand_i(operand_i), .PC_i(PC_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .pcb_o(pcb_o), .opcode_o(opcode_o), .riA_o(riA_o), .riB_o(riB_o),
    .operand_o(operand_o), .pcrel_target_o(pcrel_target_o), .PC_o(PC_o),
    .bad_o(bad_o), .fwd_a_o(fwd_a_o), .fwd_b_o(fwd_b_o)
  );

  typedef struct {
    logic [15:0] op;
    logic [31:0] opnd;
    logic [31:0] pc;
    logic [3:0]  ria;
    logic [3:0]  rib;
    logic [31:0] x_opnd;
    logic [31:0] x_tgt;
    logic        x_bad;
    logic [5:0]  x_pcb;
    logic [3:0]  x_fa;
    logic [3:0]  x_fb;
  } vec_t;

  vec_t vecs [15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [15:0] op, input logic [31:0] opnd, input logic [31:0] pc);
    in_valid_i = 1'b1;
    opcode_i   = op;
    operand_i  = opnd;
    PC_i       = pc;
  endtask

  task automatic check_zero(input string tag);
    check({tag, " in_ready"},  32'(in_ready_o), 32'd0);
    check({tag, " out_valid"}, 32'(out_valid_o), 32'd0);
    check({tag, " pcb"},       32'(pcb_o), 32'd0);
    check({tag, " opcode"},    32'(opcode_o), 32'd0);
    check({tag, " riA"},       32'(riA_o), 32'd0);
    check({tag, " riB"},       32'(riB_o), 32'd0);
    check({tag, " operand"},   operand_o, 32'd0);
    check({tag, " target"},    pcrel_target_o, 32'd0);
    check({tag, " PC"},        PC_o, 32'd0);
    check({tag, " bad"},       32'(bad_o), 32'd0);
    check({tag, " fwd_a"},     32'(fwd_a_o), 32'd0);
    check({tag, " fwd_b"},     32'(fwd_b_o), 32'd0);
  endtask

  initial begin
    //           op       opnd          pc            riA    riB    operand       target        bad   pcb     fwd_a  fwd_b
    vecs[0]  = '{16'h8301, 32'hFFFFFFFF, 32'h00000010, 4'h3, 4'h1, 32'h00000001, 32'h00000000, 1'b0, 6'h28, 4'h0, 4'h0};
    vecs[1]  = '{16'h0553, 32'hDEADBEEF, 32'h00000012, 4'h5, 4'h3, 32'hDEADBEEF, 32'h00000000, 1'b0, 6'h28, 4'h0, 4'h1};
    vecs[2]  = '{16'h0533, 32'h12345678, 32'h00000014, 4'h3, 4'h3, 32'h12345678, 32'h00000000, 1'b0, 6'h28, 4'h4, 4'h4};
    vecs[3]  = '{16'hC010, 32'hAAAAAAAA, 32'h00001000, 4'h0, 4'h0, 32'h00000000, 32'h00001022, 1'b0, 6'h00, 4'h0, 4'h0};
    vecs[4]  = '{16'hC3FF, 32'hAAAAAAAA, 32'h00001000, 4'h3, 4'hF, 32'h00000000, 32'h00001000, 1'b0, 6'h00, 4'h4, 4'h0};
    vecs[5]  = '{16'hC200, 32'h00000000, 32'h00000000, 4'h2, 4'h0, 32'h00000000, 32'hFFFFFC02, 1'b0, 6'h00, 4'h0, 4'h0};
    vecs[6]  = '{16'h1400, 32'h11111111, 32'h00000020, 4'h0, 4'h0, 32'h11111111, 32'h00000000, 1'b1, 6'h00, 4'h0, 4'h0};
    vecs[7]  = '{16'h3F00, 32'h22222222, 32'h00000022, 4'h0, 4'h0, 32'h22222222, 32'h00000000, 1'b1, 6'h00, 4'h0, 4'h0};
    vecs[8]  = '{16'hE800, 32'h00000005, 32'h00002000, 4'h8, 4'h0, 32'h00000000, 32'h00000000, 1'b1, 6'h00, 4'h0, 4'h0};
    vecs[9]  = '{16'hF000, 32'h00000005, 32'h00002000, 4'h0, 4'h0, 32'h00000000, 32'h00000000, 1'b1, 6'h00, 4'h0, 4'h0};
    vecs[10] = '{16'h0F00, 32'h33333333, 32'h00000024, 4'h0, 4'h0, 32'h33333333, 32'h00000000, 1'b0, 6'h00, 4'h0, 4'h0};
    vecs[11] = '{16'h8A07, 32'h00000000, 32'h00000030, 4'hA, 4'h7, 32'h00000007, 32'h00000000, 1'b0, 6'h28, 4'h0, 4'h0};
    vecs[12] = '{16'hA5FF, 32'h00000000, 32'h00000032, 4'h5, 4'hF, 32'h000000FF, 32'h00000000, 1'b0, 6'h00, 4'h0, 4'h0};
    vecs[13] = '{16'h07AA, 32'h00000044, 32'h00000034, 4'hA, 4'hA, 32'h00000044, 32'h00000000, 1'b0, 6'h34, 4'h4, 4'h4};
    vecs[14] = '{16'h02AB, 32'h00000055, 32'h00000036, 4'hA, 4'hB, 32'h00000055, 32'h00000000, 1'b0, 6'h20, 4'h3, 4'h0};

    rst_i = 1'b0; flush_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b0;
    opcode_i = '0; operand_i = '0; PC_i = '0;

    // Reset state, then release.
    @(negedge clk);
    @(negedge clk);
    check_zero("reset");
    rst_i = 1'b1;
    @(negedge clk);
    check("release in_ready", 32'(in_ready_o), 32'd1);
    check("release out_valid", 32'(out_valid_o), 32'd0);

    // Decode table: one instruction in flight at a time, consumed immediately.
    out_ready_i = 1'b1;
    for (int i = 0; i < 15; i++) begin
      push(vecs[i].op, vecs[i].opnd, vecs[i].pc);
      @(negedge clk);
      in_valid_i = 1'b0;
      check($sformatf("v%0d out_valid", i), 32'(out_valid_o), 32'd1);
      check($sformatf("v%0d opcode", i),    32'(opcode_o), 32'(vecs[i].op));
      check($sformatf("v%0d PC", i),        PC_o, vecs[i].pc);
      check($sformatf("v%0d riA", i),       32'(riA_o), 32'(vecs[i].ria));
      check($sformatf("v%0d riB", i),       32'(riB_o), 32'(vecs[i].rib));
      check($sformatf("v%0d operand", i),   operand_o, vecs[i].x_opnd);
      check($sformatf("v%0d target", i),    pcrel_target_o, vecs[i].x_tgt);
      check($sformatf("v%0d bad", i),       32'(bad_o), 32'(vecs[i].x_bad));
      check($sformatf("v%0d pcb", i),       32'(pcb_o), 32'(vecs[i].x_pcb));
      check($sformatf("v%0d fwd_a", i),     32'(fwd_a_o), 32'(vecs[i].x_fa));
      check($sformatf("v%0d fwd_b", i),     32'(fwd_b_o), 32'(vecs[i].x_fb));
      @(negedge clk);
      check($sformatf("v%0d drained", i),   32'(out_valid_o), 32'd0);
    end

    // Backpressure: fill, stall, then simultaneous accept and consume.
    out_ready_i = 1'b0;
    push(16'h0111, 32'h0, 32'h100);
    @(negedge clk);
    check("bp ready after 1", 32'(in_ready_o), 32'd1);
    push(16'h0122, 32'h0, 32'h102);
    @(negedge clk);
    check("bp full ready", 32'(in_ready_o), 32'd0);
    check("bp full valid", 32'(out_valid_o), 32'd1);
    check("bp head 1", 32'(opcode_o), 32'h0111);
    push(16'h0133, 32'h0, 32'h104);
    @(negedge clk);
    check("bp stall ready", 32'(in_ready_o), 32'd0);
    check("bp stall head", 32'(opcode_o), 32'h0111);
    out_ready_i = 1'b1;
    @(negedge clk);
    check("bp head 2", 32'(opcode_o), 32'h0122);
    check("bp ready again", 32'(in_ready_o), 32'd1);
    check("bp valid 2", 32'(out_valid_o), 32'd1);
    @(negedge clk);
    in_valid_i = 1'b0;
    check("bp head 3", 32'(opcode_o), 32'h0133);
    check("bp valid 3", 32'(out_valid_o), 32'd1);
    check("bp ready 3", 32'(in_ready_o), 32'd1);
    @(negedge clk);
    check("bp drained", 32'(out_valid_o), 32'd0);

    // Flush with two entries queued and an input presented.
    out_ready_i = 1'b0;
    push(16'h8301, 32'h0, 32'h200);
    @(negedge clk);
    push(16'h0111, 32'h0, 32'h202);
    @(negedge clk);
    check("fl queued valid", 32'(out_valid_o), 32'd1);
    check("fl queued full", 32'(in_ready_o), 32'd0);
    flush_i = 1'b1;
    out_ready_i = 1'b1;
    push(16'h0122, 32'h0, 32'h204);
    @(negedge clk);
    flush_i = 1'b0;
    in_valid_i = 1'b0;
    check("fl out_valid", 32'(out_valid_o), 32'd0);
    check("fl in_ready", 32'(in_ready_o), 32'd1);
    push(16'h0553, 32'h0, 32'h206);
    @(negedge clk);
    in_valid_i = 1'b0;
    check("fl next valid", 32'(out_valid_o), 32'd1);
    check("fl next opcode", 32'(opcode_o), 32'h0553);
    check("fl hist fwd_a", 32'(fwd_a_o), 32'd0);
    check("fl hist fwd_b", 32'(fwd_b_o), 32'd0);
    @(negedge clk);
    check("fl dropped", 32'(out_valid_o), 32'd0);

    // Reset mid-stream with an input presented.
    out_ready_i = 1'b0;
    push(16'h8301, 32'h0, 32'h300);
    @(negedge clk);
    push(16'h0553, 32'h0, 32'h302);
    @(negedge clk);
    check("rs queued valid", 32'(out_valid_o), 32'd1);
    push(16'h0122, 32'h0, 32'h304);
    rst_i = 1'b0;
    @(negedge clk);
    check_zero("rs mid");
    @(negedge clk);
    check("rs hold ready", 32'(in_ready_o), 32'd0);
    rst_i = 1'b1;
    in_valid_i = 1'b0;
    @(negedge clk);
    check("rs release ready", 32'(in_ready_o), 32'd1);
    check("rs release valid", 32'(out_valid_o), 32'd0);
    out_ready_i = 1'b1;
    push(16'h0553, 32'h0, 32'h306);
    @(negedge clk);
    in_valid_i = 1'b0;
    check("rs next valid", 32'(out_valid_o), 32'd1);
    check("rs next opcode", 32'(opcode_o), 32'h0553);
    check("rs hist fwd_b", 32'(fwd_b_o), 32'd0);
    @(negedge clk);
    check("rs drained", 32'(out_valid_o), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
